// File: rtl/insn_decode_queue_pkg.sv
// Shared opcode, class and queue-entry definitions
// for the decode queue between fetch and execute.
package insn_decode_queue_pkg;

  localparam int CODE_W = 16;

  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_FLOAD   = 7'b0000111;
  localparam logic [6:0] OPC_FSTORE  = 7'b0100111;
  localparam logic [6:0] OPC_OPFP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD   = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD  = 7'b1001111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam int CLS_J       = 0;
  localparam int CLS_JALR    = 1;
  localparam int CLS_LUI     = 2;
  localparam int CLS_AUIPC   = 3;
  localparam int CLS_B       = 4;
  localparam int CLS_R       = 5;
  localparam int CLS_S       = 6;
  localparam int CLS_I       = 7;
  localparam int CLS_LOAD    = 8;
  localparam int CLS_CSR     = 9;
  localparam int CLS_FLOAD   = 10;
  localparam int CLS_FSTORE  = 11;
  localparam int CLS_OPFP    = 12;
  localparam int CLS_FMA     = 13;
  localparam int CLS_OPIMM32 = 14;
  localparam int CLS_OP32    = 15;

  typedef struct packed {
    logic [31:0]       insn;
    logic [CODE_W-1:0] code;
    logic              illegal;
  } dq_entry_t;

  function automatic logic [CODE_W-1:0] cls_bit(
    input int idx
  );
    return CODE_W'(1) << idx;
  endfunction

endpackage

// File: rtl/insn_decode_queue_class_decode.sv
// Combinational opcode classifier: one-hot class
// code, or illegal when unknown or disabled.
module insn_class_decode
  import insn_decode_queue_pkg::*;
#(
  parameter bit ENABLE_FP   = 1'b1,
  parameter bit ENABLE_RV64 = 1'b1
) (
  input  logic [6:0]        opcode,
  output logic [CODE_W-1:0] code,
  output logic              illegal
);

  logic [CODE_W-1:0] cls;
  logic              is_fma;

  assign is_fma = (opcode == OPC_FMADD)
               || (opcode == OPC_FMSUB)
               || (opcode == OPC_FNMSUB)
               || (opcode == OPC_FNMADD);

  // Map opcode to its class; disabled classes fall to zero
  always_comb begin
    cls = '0;
    unique case (1'b1)
      (opcode == OPC_JAL):     cls = cls_bit(CLS_J);
      (opcode == OPC_JALR):    cls = cls_bit(CLS_JALR);
      (opcode == OPC_LUI):     cls = cls_bit(CLS_LUI);
      (opcode == OPC_AUIPC):   cls = cls_bit(CLS_AUIPC);
      (opcode == OPC_BRANCH):  cls = cls_bit(CLS_B);
      (opcode == OPC_OP):      cls = cls_bit(CLS_R);
      (opcode == OPC_STORE):   cls = cls_bit(CLS_S);
      (opcode == OPC_OPIMM):   cls = cls_bit(CLS_I);
      (opcode == OPC_LOAD):    cls = cls_bit(CLS_LOAD);
      (opcode == OPC_SYSTEM):  cls = cls_bit(CLS_CSR);
      (opcode == OPC_FLOAD):
        cls = ENABLE_FP ? cls_bit(CLS_FLOAD) : '0;
      (opcode == OPC_FSTORE):
        cls = ENABLE_FP ? cls_bit(CLS_FSTORE) : '0;
      (opcode == OPC_OPFP):
        cls = ENABLE_FP ? cls_bit(CLS_OPFP) : '0;
      is_fma:
        cls = ENABLE_FP ? cls_bit(CLS_FMA) : '0;
      (opcode == OPC_OPIMM32):
        cls = ENABLE_RV64 ? cls_bit(CLS_OPIMM32) : '0;
      (opcode == OPC_OP32):
        cls = ENABLE_RV64 ? cls_bit(CLS_OP32) : '0;
      default: cls = '0;
    endcase
  end

  assign code    = cls;
  assign illegal = (cls == '0);

endmodule

// File: rtl/insn_decode_queue.sv
// Decode stage with a DEPTH-entry result FIFO so
// fetch and execute can stall independently.
module insn_decode_queue
  import insn_decode_queue_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter bit ENABLE_FP   = 1'b1,
  parameter bit ENABLE_RV64 = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] code,
  output logic              illegal,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rs3,
  output logic [2:0]        funct3,
  output logic [31:0]       insn_out,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int AW = $clog2(DEPTH);

  logic [CODE_W-1:0] dec_code;
  logic              dec_illegal;
  dq_entry_t         wr_entry;
  dq_entry_t         head;
  dq_entry_t         mem [DEPTH];

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  cnt;

  insn_class_decode #(
    .ENABLE_FP   (ENABLE_FP),
    .ENABLE_RV64 (ENABLE_RV64)
  ) u_dec (
    .opcode  (insn[6:0]),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  assign wr_entry = '{
    insn:    insn,
    code:    dec_code,
    illegal: dec_illegal
  };

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid && !full && !flush;
  assign pop  = !empty && out_ready && !flush;

  // Pointer update; flush collapses read onto write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; stale slots are masked by empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Saturating count of accepted illegal insns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && dec_illegal
                 && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign code          = head.code;
  assign illegal       = head.illegal;
  assign insn_out      = head.insn;
  assign rd            = head.insn[11:7];
  assign rs1           = head.insn[19:15];
  assign rs2           = head.insn[24:20];
  assign rs3           = head.insn[31:27];
  assign funct3        = head.insn[14:12];
  assign illegal_count = cnt;

endmodule

// File: tb/tb_insn_decode_queue.sv
// Randomized and directed bench for the decode
// queue against a queue-based reference model.
module tb_insn_decode_queue;

  localparam int DEPTH = 2;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready;
  logic [31:0] a_insn, a_insn_out;
  logic        a_out_valid, a_out_ready, a_illegal;
  logic [15:0] a_code, a_cnt;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_rs3;
  logic [2:0]  a_funct3;

  logic        b_flush, b_in_valid, b_in_ready;
  logic [31:0] b_insn, b_insn_out;
  logic        b_out_valid, b_out_ready, b_illegal;
  logic [15:0] b_code;
  logic [1:0]  b_cnt;
  logic [4:0]  b_rd, b_rs1, b_rs2, b_rs3;
  logic [2:0]  b_funct3;

  insn_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .insn(a_insn), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .code(a_code),
    .illegal(a_illegal), .rd(a_rd), .rs1(a_rs1),
    .rs2(a_rs2), .rs3(a_rs3), .funct3(a_funct3),
    .insn_out(a_insn_out), .illegal_count(a_cnt)
  );

  insn_decode_queue #(
    .DEPTH(2), .ENABLE_FP(1'b0),
    .ENABLE_RV64(1'b0), .CNT_W(2)
  ) dut_nofp (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .insn(b_insn), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .code(b_code),
    .illegal(b_illegal), .rd(b_rd), .rs1(b_rs1),
    .rs2(b_rs2), .rs3(b_rs3), .funct3(b_funct3),
    .insn_out(b_insn_out), .illegal_count(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  bit [6:0] opc_tab [19] = '{
    7'h6F, 7'h67, 7'h37, 7'h17, 7'h63, 7'h33,
    7'h23, 7'h13, 7'h03, 7'h73, 7'h07, 7'h27,
    7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h1B,
    7'h3B
  };
  int cls_tab [19] = '{
    0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
    12, 13, 13, 13, 13, 14, 15
  };

  bit [31:0] mq [$];
  int        mcnt;

  task automatic chk(string tag,
                     logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int ref_cls(bit [31:0] i,
                                 bit fp,
                                 bit rv64);
    for (int k = 0; k < 19; k++) begin
      if (opc_tab[k] == i[6:0]) begin
        if (!fp && cls_tab[k] >= 10
            && cls_tab[k] <= 13) return -1;
        if (!rv64 && cls_tab[k] >= 14) return -1;
        return cls_tab[k];
      end
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_code(int c);
    logic [15:0] r;
    r = '0;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic compare();
    bit [31:0] h;
    bit        ne;
    int        c;
    ne = (mq.size() > 0);
    h  = ne ? mq[0] : 32'h0;
    c  = ref_cls(h, 1'b1, 1'b1);
    chk("in_ready", a_in_ready, mq.size() < DEPTH);
    chk("out_valid", a_out_valid, ne);
    chk("code", a_code, ne ? ref_code(c) : 16'h0);
    chk("illegal", a_illegal, ne && (c < 0));
    chk("insn_out", a_insn_out, h);
    chk("rd", a_rd, h[11:7]);
    chk("rs1", a_rs1, h[19:15]);
    chk("rs2", a_rs2, h[24:20]);
    chk("rs3", a_rs3, h[31:27]);
    chk("funct3", a_funct3, h[14:12]);
    chk("count", a_cnt, mcnt);
  endtask

  task automatic step(bit v, bit [31:0] i,
                      bit rdy, bit fl);
    bit push, pop;
    @(negedge clk);
    a_in_valid  = v;
    a_insn      = i;
    a_out_ready = rdy;
    a_flush     = fl;
    push = v && (mq.size() < DEPTH) && !fl;
    pop  = (mq.size() > 0) && rdy && !fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(i);
        if (ref_cls(i, 1'b1, 1'b1) < 0
            && mcnt < CMAX) mcnt++;
      end
    end
    #1 compare();
  endtask

  task automatic bstep(bit v, bit [31:0] i,
                       bit rdy);
    @(negedge clk);
    b_in_valid  = v;
    b_insn      = i;
    b_out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] r;
    bit [31:0] seq [16];
    int        k;
    bit        acc;
    int        b_exp [5] = '{1, 2, 3, 3, 3};
    bit [31:0] b_ins [5] = '{
      32'h0000_2007, 32'h0000_001B,
      32'h0000_007F, 32'h0000_0002,
      32'h0000_007F
    };

    reset = 1'b1;
    a_flush = 0; a_in_valid = 0;
    a_out_ready = 0; a_insn = '0;
    b_flush = 0; b_in_valid = 0;
    b_out_ready = 0; b_insn = '0;
    mcnt = 0;
    #12;
    compare();
    chk("b_rst_valid", b_out_valid, 1'b0);
    chk("b_rst_ready", b_in_ready, 1'b1);
    chk("b_rst_count", b_cnt, 2'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int j = 0; j < 19; j++) begin
      r = {20'hA5C3B, 5'd0, opc_tab[j]};
      r[14:12] = 3'b000;
      step(1'b1, r, 1'b1, 1'b0);
      chk("t1_code", a_code, ref_code(cls_tab[j]));
      chk("t1_illegal", a_illegal, 1'b0);
      chk("t1_count", a_cnt, 16'd0);
    end
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    chk("t2_code_a", a_code, 16'h0);
    chk("t2_ill_a", a_illegal, 1'b1);
    step(1'b1, 32'h0000_0002, 1'b1, 1'b0);
    chk("t2_code_b", a_code, 16'h0);
    chk("t2_ill_b", a_illegal, 1'b1);
    chk("t2_count", a_cnt, 16'd2);
    step(1'b0, '0, 1'b1, 1'b0);

    for (int j = 0; j < 16; j++)
      seq[j] = {j[4:0], 20'h12345, 7'h33};
    step(1'b1, seq[0], 1'b0, 1'b0);
    step(1'b1, seq[1], 1'b0, 1'b0);
    chk("t3_full", a_in_ready, 1'b0);
    step(1'b1, seq[2], 1'b0, 1'b0);
    chk("t3_held", a_in_ready, 1'b0);
    chk("t3_head", a_insn_out, seq[0]);
    k = 2;
    while (k < 13) begin
      acc = (mq.size() < DEPTH);
      step(1'b1, seq[k], 1'b1, 1'b0);
      if (acc) k++;
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0093, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_0033, 1'b0, 1'b1);
    chk("t4_valid", a_out_valid, 1'b0);
    chk("t4_ready", a_in_ready, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t4_gone", a_out_valid, 1'b0);

    step(1'b1, 32'h0000_2007, 1'b1, 1'b0);
    chk("t5_code", a_code, 16'h0400);
    chk("t5_rd", a_rd, 5'd0);
    chk("t5_f3", a_funct3, 3'b010);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    for (int j = 0; j < 5; j++) begin
      bstep(1'b1, b_ins[j], j != 0);
      chk("t6_valid", b_out_valid, 1'b1);
      chk("t6_code", b_code, 16'h0);
      chk("t6_ill", b_illegal, 1'b1);
      chk("t6_count", b_cnt, b_exp[j]);
      if (j == 0) chk("t5_f3b", b_funct3, 3'b010);
    end
    bstep(1'b0, '0, 1'b0);

    #3 reset = 1'b1;
    #1;
    chk("ar_b_count", b_cnt, 2'd0);
    chk("ar_b_valid", b_out_valid, 1'b0);
    chk("ar_a_valid", a_out_valid, 1'b0);
    chk("ar_a_count", a_cnt, 16'd0);
    chk("ar_a_ready", a_in_ready, 1'b1);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 2000; n++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0)
        r[6:0] = opc_tab[$urandom_range(0, 18)];
      step($urandom_range(0, 3) != 0, r,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/insn_decode_queue.md
Name: insn_decode_queue

Overview:
- Registered, buffered successor to the combinational opcode decoder; sits between fetch and execute in the RV64F core.
- Accepts 32-bit instructions on a valid/ready handshake and classifies each opcode into a one-hot class code, extended to RV64 word ops and F-extension opcodes.
- Extracts register and funct fields and flags illegal opcodes.
- Buffers decoded results in a DEPTH-entry FIFO so fetch and execute stall independently; supports pipeline flush.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, >= 2.
- ENABLE_FP, 1, when 0 the F opcodes (classes 10-13) decode as illegal.
- ENABLE_RV64, 1, when 0 OP-IMM-32/OP-32 (classes 14-15) decode as illegal.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  insn is valid
- in_ready  out  1  queue can accept this cycle
- insn  in  32  raw instruction
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes head this cycle
- code  out  16  one-hot class of head entry
- illegal  out  1  head entry is illegal
- rd, rs1, rs2, rs3  out  5 each  insn[11:7], [19:15], [24:20], [31:27] of head
- funct3  out  3  insn[14:12] of head
- insn_out  out  32  raw head instruction
- illegal_count  out  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: FIFO empty, out_valid=0, in_ready=1, illegal_count=0. All head data outputs read 0 while empty.
- Class map (bit: opcode):
  - 0 J 1101111; 1 JALR 1100111; 2 LUI 0110111; 3 AUIPC 0010111
  - 4 B 1100011; 5 R 0110011; 6 S 0100011; 7 I-ALU 0010011
  - 8 LOAD 0000011; 9 CSR 1110011
  - 10 FLOAD 0000111; 11 FSTORE 0100111; 12 OP-FP 1010011
  - 13 FMA 1000011/1000111/1001011/1001111
  - 14 OP-IMM-32 0011011; 15 OP-32 0111011
- Illegal decode: any other opcode, or a class disabled by its parameter, gives code=0 and illegal=1. Exactly one of {one bit of code, illegal} is set per valid entry.
- Decode is combinational on insn at the input. The result (code, illegal, fields, raw insn) is written into the FIFO.
- Push: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- in_ready = !full, derived from registered state only. It does not depend on out_ready: when full, a same-cycle pop does not enable a push.
- Latency: an insn pushed into an empty queue at edge N appears with out_valid=1 after edge N. Sustained throughput is 1/cycle when out_ready=1.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- Pointers are log2(DEPTH) bits plus a wrap bit.
  - full: pointers equal, wrap bits differ.
  - empty: pointers and wrap bits equal.
  - Wrap-around is seamless.
- flush: at the next edge the FIFO is empty; the same-cycle input is dropped and no pop occurs. out_valid=0 the cycle after. in_ready returns to 1.
- illegal_count increments by 1 on each push whose decode is illegal. It saturates at 2^CNT_W-1, is unaffected by flush, and is cleared only by reset.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - opcode localparams (OPC_JAL ... OPC_OP32)
  - class bit index constants (CLS_J=0 ... CLS_OP32=15)
  - CODE_W=16
- One sub-module, insn_class_decode: combinational opcode -> {code, illegal} with ENABLE_FP/ENABLE_RV64 parameters. It is reused by the legacy decoder testbench style.

Test Plan:
1. Reset then push each of the 19 legal opcodes (funct bits 0) with out_ready=1 -> each appears one cycle later with the matching single code bit set, illegal=0, count=0.
2. Push insn=0x0000007F, then 0x00000002 (low bits 10) -> both code=0, illegal=1, illegal_count=2.
3. out_ready=0, push 3 insns with DEPTH=2 -> in_ready=0 after 2 pushes, third held. Then release out_ready -> outputs in order, no loss or duplication, pointers wrap correctly over 10 further pushes.
4. Queue holding 2 entries, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped insn never appears.
5. ENABLE_FP=0 instance, push 0x00002007 (FLW) -> code=0, illegal=1. ENABLE_FP=1 -> code=16'h0400, rd=0, funct3=3'b010.
6. CNT_W=2, push 5 illegal insns -> illegal_count 1,2,3,3,3. Assert reset asynchronously between edges -> illegal_count=0 and out_valid=0 immediately.
